// File: rtl/wb_burst_fetch.sv
`default_nettype none
// =============================================================================
// wb_burst_fetch : Wishbone 4-beat incremental burst reader feeding a FWFT FIFO.
// Optional macro WB_BURST_FETCH_TIMEOUT_EN adds a 1023-cycle ack timeout.
// Revision 1.0
// =============================================================================
module wb_burst_fetch #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADR_W      = 24,
    parameter int LEN_W      = 16
) (
    input  logic                        wb_clk,
    input  logic                        wb_rst_n,
    input  logic                        start,
    input  logic [ADR_W-1:0]            base_adr,
    input  logic [LEN_W-1:0]            len,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [ADR_W-1:0]            wb_adr,
    output logic [2:0]                  wb_cti,
    output logic [3:0]                  wb_sel,
    output logic                        wb_we,
    output logic                        wb_stb,
    output logic                        wb_cyc,
    input  logic [31:0]                 wb_dat_i,
    input  logic                        wb_ack,
    input  logic                        rd_en,
    output logic [31:0]                 rd_data,
    output logic                        rd_empty,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] SPACE_LIMIT = LVL_W'(FIFO_DEPTH - 4);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        BURST      = 2'd2,
        GAP        = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [ADR_W-1:0]   adr, adr_nx;
    logic [LEN_W-1:0]   bursts, bursts_nx, bursts_init;
    logic [1:0]         beat, beat_nx;
    logic               abort_lat, abort_nx;
    logic               busy_nx, done_nx, err_nx;
    logic               has_space, tmo_hit;
    logic               unused_adr_lsb;

    logic [31:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   count;
    logic               push, pop;

    assign unused_adr_lsb = ^base_adr[3:0];

    // ceil(len/4) without needing a wider adder
    assign bursts_init = {2'b00, len[LEN_W-1:2]} + {{(LEN_W-1){1'b0}}, |len[1:0]};
    assign has_space   = (count <= SPACE_LIMIT);

    assign wb_adr = adr;
    assign wb_stb = (state == BURST);
    assign wb_cyc = (state == BURST);
    assign wb_sel = 4'b1111;
    assign wb_we  = 1'b0;
    assign wb_cti = (state != BURST) ? 3'b000 :
                    (beat == 2'd3)   ? 3'b111 : 3'b010;

`ifdef WB_BURST_FETCH_TIMEOUT_EN
    logic [9:0] tmo_cnt;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            tmo_cnt <= 10'd0;
        end else if ((state != BURST) || wb_ack) begin
            tmo_cnt <= 10'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
        end
    end

    // Counter value 1022 in this cycle means the strobe has now been up 1023 cycles
    assign tmo_hit = (state == BURST) && !wb_ack && (tmo_cnt == 10'd1022);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        adr_nx    = adr;
        bursts_nx = bursts;
        beat_nx   = beat;
        abort_nx  = abort_lat | (abort & busy);
        busy_nx   = busy;
        done_nx   = 1'b0;
        err_nx    = err;
        case (state)
            IDLE: begin
                abort_nx = 1'b0;
                if (start) begin
                    adr_nx    = {base_adr[ADR_W-1:4], 4'h0};
                    bursts_nx = bursts_init;
                    beat_nx   = 2'd0;
                    err_nx    = 1'b0;
                    if (len == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        busy_nx  = 1'b1;
                        state_nx = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                if (abort || abort_lat || (bursts == '0)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    abort_nx = 1'b0;
                end else if (has_space) begin
                    state_nx = BURST;
                    beat_nx  = 2'd0;
                end
            end
            BURST: begin
                if (wb_ack) begin
                    adr_nx  = adr + ADR_W'(4);
                    beat_nx = beat + 2'd1;
                    if (beat == 2'd3) begin
                        bursts_nx = bursts - LEN_W'(1);
                        state_nx  = GAP;
                    end
                end else if (tmo_hit) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    abort_nx = 1'b0;
                end
            end
            GAP: begin
                state_nx = WAIT_SPACE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= IDLE;
            adr       <= '0;
            bursts    <= '0;
            beat      <= 2'd0;
            abort_lat <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            adr       <= adr_nx;
            bursts    <= bursts_nx;
            beat      <= beat_nx;
            abort_lat <= abort_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            err       <= err_nx;
        end
    end

    // FIFO: the space check before each burst guarantees a push never meets full
    assign push = (state == BURST) && wb_ack;
    assign pop  = rd_en && (count != '0);

    always_ff @(posedge wb_clk) begin
        if (push) begin
            mem[wr_ptr] <= wb_dat_i;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data  = mem[rd_ptr];
    assign rd_empty = (count == '0);
    assign level    = count;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_fetch.sv
`default_nettype none
// tb_wb_burst_fetch : scoreboard bench for wb_burst_fetch built with FIFO_DEPTH = 8.
module tb_wb_burst_fetch;

    localparam int FIFO_DEPTH = 8;
    localparam int ADR_W      = 24;
    localparam int LEN_W      = 16;
    localparam int LVLW       = $clog2(FIFO_DEPTH) + 1;

    logic                 wb_clk, wb_rst_n, start, abort;
    logic                 busy, done, err;
    logic [ADR_W-1:0]     base_adr, wb_adr;
    logic [LEN_W-1:0]     len;
    logic [2:0]           wb_cti;
    logic [3:0]           wb_sel;
    logic                 wb_we, wb_stb, wb_cyc, wb_ack, rd_en, rd_empty;
    logic [31:0]          wb_dat_i, rd_data;
    logic [LVLW-1:0]      level;

    int total = 0;
    int bad   = 0;

    logic [ADR_W-1:0] exp_adr[$];
    logic [2:0]       exp_cti[$];
    logic [31:0]      exp_dat[$];

    int ack_lat     = 2;
    int ack_budget  = 1000000;
    int wait_cnt    = 0;
    int done_cnt    = 0;
    int ack_seen    = 0;
    int bursts_seen = 0;
    int stb_run     = 0;
    int last_run    = 0;
    int max_level   = 0;
    logic stb_prev  = 1'b0;

    wb_burst_fetch #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADR_W      (ADR_W),
        .LEN_W      (LEN_W)
    ) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .start    (start),
        .base_adr (base_adr),
        .len      (len),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .wb_adr   (wb_adr),
        .wb_cti   (wb_cti),
        .wb_sel   (wb_sel),
        .wb_we    (wb_we),
        .wb_stb   (wb_stb),
        .wb_cyc   (wb_cyc),
        .wb_dat_i (wb_dat_i),
        .wb_ack   (wb_ack),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_empty (rd_empty),
        .level    (level)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] dat_of(input logic [ADR_W-1:0] a);
        return {8'hA5, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_bursts(input logic [ADR_W-1:0] a0, input int nb);
        logic [ADR_W-1:0] a;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 4; i++) begin
                a = a0 + ADR_W'(16 * b + 4 * i);
                exp_adr.push_back(a);
                exp_cti.push_back((i == 3) ? 3'b111 : 3'b010);
                exp_dat.push_back(dat_of(a));
            end
        end
    endtask

    task automatic do_start(input logic [ADR_W-1:0] a, input logic [LEN_W-1:0] n);
        @(posedge wb_clk); #1;
        base_adr = a;
        len      = n;
        start    = 1'b1;
        @(posedge wb_clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge wb_clk);
            n++;
        end
        check({name, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        @(posedge wb_clk); #1;
        rd_en = 1'b1;
        while (!rd_empty && n < 100) begin
            @(posedge wb_clk); #1;
            n++;
        end
        rd_en = 1'b0;
        check({name, "_data_left"}, 64'(exp_dat.size()), 64'd0);
        check({name, "_level0"}, 64'(level), 64'd0);
    endtask

    // Responder: acks ack_lat cycles after the strobe rises, then back-to-back
    initial begin
        wb_ack   = 1'b0;
        wb_dat_i = 32'h0;
        forever begin
            @(posedge wb_clk); #1;
            if (wb_cyc && wb_stb && ack_budget > 0 && wait_cnt >= ack_lat) begin
                wb_ack   = 1'b1;
                wb_dat_i = dat_of(wb_adr);
                ack_budget--;
            end else begin
                wb_ack = 1'b0;
                if (wb_cyc && wb_stb) wait_cnt++;
                else wait_cnt = 0;
            end
        end
    end

    // Monitor: compares bus beats and FIFO pops against the scoreboard queues
    initial begin
        forever begin
            @(negedge wb_clk);
            if (wb_stb) begin
                if (!stb_prev) begin
                    bursts_seen++;
                    stb_run = 0;
                end
                stb_run++;
            end else if (stb_prev) begin
                last_run = stb_run;
            end
            stb_prev = wb_stb;
            if (done) done_cnt++;
            if (int'(level) > max_level) max_level = int'(level);
            if (wb_rst_n && wb_cyc && wb_stb && wb_ack) begin
                ack_seen++;
                if (exp_adr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_unexpected: got adr %0h expected no beat", wb_adr);
                end else begin
                    check("beat_adr", 64'(wb_adr), 64'(exp_adr.pop_front()));
                    check("beat_cti", 64'(wb_cti), 64'(exp_cti.pop_front()));
                    check("beat_sel_we", 64'({wb_sel, wb_we}), 64'h1E);
                end
            end
            if (wb_rst_n && rd_en && !rd_empty) begin
                if (exp_dat.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got %0h expected no data", rd_data);
                end else begin
                    check("pop_data", 64'(rd_data), 64'(exp_dat.pop_front()));
                end
            end
        end
    end

    initial begin
        int d0;
        int b0;
        int a0;
        int n;

        wb_rst_n = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        base_adr = '0;
        len      = '0;
        rd_en    = 1'b0;
        repeat (3) @(posedge wb_clk);
        #1;
        check("rst_ctrl", 64'({busy, done, err, wb_stb, wb_cyc}), 64'd0);
        check("rst_adr", 64'(wb_adr), 64'd0);
        check("rst_cti", 64'(wb_cti), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_empty", 64'(rd_empty), 64'd1);
        wb_rst_n = 1'b1;

        // 1: two bursts from an unaligned base, slow first ack
        ack_lat = 6;
        d0 = done_cnt;
        b0 = bursts_seen;
        expect_bursts(24'h001230, 2);
        do_start(24'h001234, 16'd8);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done("t1", 300);
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_level", 64'(level), 64'd8);
        check("t1_bursts", 64'(bursts_seen - b0), 64'd2);
        check("t1_beats_left", 64'(exp_adr.size()), 64'd0);
        check("t1_err", 64'(err), 64'd0);
        drain("t1");
        check("t1_done_once", 64'(done_cnt - d0), 64'd1);

        // 2: FIFO full stall and resume after pops
        ack_lat   = 2;
        d0        = done_cnt;
        b0        = bursts_seen;
        max_level = 0;
        expect_bursts(24'h000100, 4);
        do_start(24'h000100, 16'd16);
        n = 0;
        while (level != LVLW'(8) && n < 200) begin
            @(negedge wb_clk);
            n++;
        end
        repeat (10) @(negedge wb_clk);
        check("t2_level_full", 64'(level), 64'd8);
        check("t2_stall_stb", 64'({wb_stb, wb_cyc}), 64'd0);
        check("t2_busy", 64'(busy), 64'd1);
        check("t2_bursts_stall", 64'(bursts_seen - b0), 64'd2);
        @(posedge wb_clk); #1;
        rd_en = 1'b1;
        repeat (4) @(posedge wb_clk);
        #1;
        rd_en = 1'b0;
        n = 0;
        while (bursts_seen - b0 < 3 && n < 100) begin
            @(negedge wb_clk);
            n++;
        end
        check("t2_third_burst", 64'(bursts_seen - b0), 64'd3);
        @(posedge wb_clk); #1;
        rd_en = 1'b1;
        wait_done("t2", 300);
        drain("t2");
        check("t2_max_level", 64'(max_level), 64'd8);
        check("t2_bursts", 64'(bursts_seen - b0), 64'd4);
        check("t2_done_once", 64'(done_cnt - d0), 64'd1);

        // 3: length rounding, then zero length
        d0 = done_cnt;
        b0 = bursts_seen;
        expect_bursts(24'h000200, 2);
        do_start(24'h000200, 16'd5);
        wait_done("t3", 300);
        check("t3_level", 64'(level), 64'd8);
        check("t3_bursts", 64'(bursts_seen - b0), 64'd2);
        drain("t3");
        d0 = done_cnt;
        b0 = bursts_seen;
        do_start(24'h000280, 16'd0);
        check("t3_len0_done", 64'(done), 64'd1);
        check("t3_len0_busy", 64'(busy), 64'd0);
        repeat (6) @(negedge wb_clk);
        check("t3_len0_nobus", 64'(bursts_seen - b0), 64'd0);
        check("t3_len0_done_once", 64'(done_cnt - d0), 64'd1);

        // 4: abort during beat 1 of the first burst
        ack_lat = 3;
        d0 = done_cnt;
        b0 = bursts_seen;
        a0 = ack_seen;
        expect_bursts(24'h000400, 1);
        do_start(24'h000400, 16'd12);
        n = 0;
        while (ack_seen == a0 && n < 100) begin
            @(posedge wb_clk);
            n++;
        end
        #1;
        abort = 1'b1;
        @(posedge wb_clk); #1;
        abort = 1'b0;
        wait_done("t4", 300);
        check("t4_level", 64'(level), 64'd4);
        check("t4_bursts", 64'(bursts_seen - b0), 64'd1);
        check("t4_beats_left", 64'(exp_adr.size()), 64'd0);
        drain("t4");
        check("t4_done_once", 64'(done_cnt - d0), 64'd1);

        // 5: asynchronous reset after two acks, then a clean transfer
        ack_lat    = 2;
        ack_budget = 2;
        a0 = ack_seen;
        exp_adr.push_back(24'h000500);
        exp_cti.push_back(3'b010);
        exp_adr.push_back(24'h000504);
        exp_cti.push_back(3'b010);
        do_start(24'h000500, 16'd8);
        n = 0;
        while (ack_seen - a0 < 2 && n < 100) begin
            @(posedge wb_clk);
            n++;
        end
        repeat (3) @(posedge wb_clk);
        #1;
        check("t5_stb_held", 64'(wb_stb), 64'd1);
        check("t5_level_part", 64'(level), 64'd2);
        wb_rst_n = 1'b0;
        #1;
        check("t5_rst_bus", 64'({wb_cyc, wb_stb}), 64'd0);
        check("t5_rst_level", 64'(level), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge wb_clk);
        wb_rst_n   = 1'b1;
        ack_budget = 1000000;
        expect_bursts(24'h000600, 1);
        do_start(24'h000600, 16'd4);
        wait_done("t5", 300);
        check("t5_level", 64'(level), 64'd4);
        drain("t5");

        // 7: address wrap past the top of the space
        d0 = done_cnt;
        expect_bursts(24'hFFFFF0, 2);
        do_start(24'hFFFFF8, 16'd8);
        wait_done("t7", 300);
        check("t7_level", 64'(level), 64'd8);
        check("t7_err", 64'(err), 64'd0);
        drain("t7");

`ifdef WB_BURST_FETCH_TIMEOUT_EN
        // 6: responder never acks
        ack_budget = 0;
        b0 = bursts_seen;
        do_start(24'h000700, 16'd4);
        wait_done("t6", 1200);
        check("t6_err", 64'(err), 64'd1);
        check("t6_stb_run", 64'(last_run), 64'd1023);
        check("t6_bus_idle", 64'({wb_cyc, wb_stb, busy}), 64'd0);
        ack_budget = 1000000;
        expect_bursts(24'h000800, 1);
        do_start(24'h000800, 16'd4);
        check("t6_err_cleared", 64'(err), 64'd0);
        wait_done("t6b", 300);
        drain("t6b");
`endif

        repeat (4) @(posedge wb_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_burst_fetch.md
Name: wb_burst_fetch

Overview:
- Wishbone read initiator (bus master) that issues 4-beat incremental burst reads to the SDRAM Wishbone responder.
- Streams the returned 32-bit words into an internal FIFO, which a consumer (video/sound DMA, loader) drains.
- Only issues a burst when the FIFO has room for all 4 beats, so it never back-pressures the responder mid-burst.
- Sits in the wb_clk domain between the DMA consumers and the SDRAM controller.

Parameters:
FIFO_DEPTH, 16, FIFO depth in 32-bit words; power of two; must be >= 8
ADR_W, 24, Wishbone byte-address width
LEN_W, 16, width of the transfer-length field, in words

Ports:
wb_clk    in   1      chipset clock; all logic on its rising edge
wb_rst_n  in   1      asynchronous active-low reset
start     in   1      one-cycle pulse; latches base_adr and len; ignored while busy
base_adr  in   ADR_W  start byte address; bits [3:0] treated as 0
len       in   LEN_W  transfer length in words; rounded up to a multiple of 4
abort     in   1      stop after the current burst completes
busy      out  1      transfer in progress
done      out  1      one-cycle pulse when the transfer ends (completed, aborted or errored)
err       out  1      sticky timeout flag; cleared by start
wb_adr    out  ADR_W  burst beat address, bits [1:0] = 0
wb_cti    out  3      3'b010 incremental on beats 0-2; 3'b111 on beat 3
wb_sel    out  4      constant 4'b1111
wb_we     out  1      constant 0
wb_stb    out  1      strobe
wb_cyc    out  1      cycle
wb_dat_i  in   32     read data from responder
wb_ack    in   1      beat acknowledge
rd_en     in   1      FIFO pop
rd_data   out  32     FIFO head word; valid whenever rd_empty = 0 (first-word fall-through)
rd_empty  out  1      FIFO empty
level     out  clog2(FIFO_DEPTH)+1  FIFO occupancy in words

Behaviour:
- Reset (async, wb_rst_n = 0): state IDLE; busy, done, err, wb_stb, wb_cyc = 0; wb_adr = 0; wb_cti = 0; FIFO empty, level = 0, rd_empty = 1.
- States: IDLE, WAIT_SPACE, BURST, GAP.
- IDLE:
  - On start, latch adr = {base_adr[ADR_W-1:4], 4'h0} and bursts = ceil(len/4); clear err.
  - len = 0: pulse done the next cycle, stay IDLE, no bus cycle.
  - Otherwise set busy and go to WAIT_SPACE.
- WAIT_SPACE:
  - If abort is seen or bursts = 0: go to IDLE, pulse done, clear busy.
  - Else if FIFO_DEPTH - level >= 4: go to BURST and assert wb_cyc/wb_stb with wb_adr = adr, beat = 0, wb_cti = 010, all in the same cycle.
- BURST, on each wb_ack:
  - push wb_dat_i into the FIFO;
  - adr += 4; wb_adr follows adr; beat += 1;
  - wb_cti = 111 once beat = 3.
- BURST, on the 4th ack: deassert wb_cyc/wb_stb in the next cycle, bursts -= 1, go to GAP.
- wb_stb/wb_cyc stay high with no ack for any number of cycles (the responder has multi-cycle latency before beat 0).
- GAP: exactly one cycle with wb_cyc/wb_stb low, so the responder sees a new request edge. Then go to WAIT_SPACE.
- abort during BURST is latched; the burst runs to its 4th ack; WAIT_SPACE then ends the transfer.
- Address wrap: adr wraps modulo 2^ADR_W without error.
- FIFO:
  - A push and a pop in the same cycle leave level unchanged.
  - A pop when empty is ignored.
  - A push can never hit full, because the space check reserves 4 slots before each burst.
  - The FIFO contents persist after done until popped; start does not flush them.
- start while busy is ignored. abort in IDLE is ignored.
- done asserts the cycle after the final ack's GAP → WAIT_SPACE evaluation, not when the FIFO drains.

Optional Feature:
- Macro: WB_BURST_FETCH_TIMEOUT_EN.
- With the macro defined:
  - A 10-bit counter runs while wb_stb = 1 and resets on every ack.
  - If it reaches 1023, drop wb_cyc/wb_stb, set err, pulse done, clear busy and go to IDLE.
  - The partial beats of the failed burst remain in the FIFO.
- Without the macro: no counter; err is tied 0; the block waits indefinitely for ack.

Test Plan:
1. start, base_adr = 0x001234, len = 8 with a responder that acks 6 cycles after stb then back-to-back → two bursts at wb_adr 0x001230..0x00123C and 0x001240..0x00124C; cti sequence 010,010,010,111 per burst; one GAP cycle between bursts; 8 words in the FIFO; done pulses once; busy drops.
2. FIFO_DEPTH = 8, len = 16, no pops → after two bursts level = 8 and the block stalls in WAIT_SPACE with stb = 0; pop 4 → the third burst starts; the FIFO never exceeds 8.
3. len = 5 → two bursts, 8 words fetched; len = 0 → done the cycle after start, no wb_cyc.
4. abort asserted during beat 1 of the first burst of len = 12 → that burst completes with 4 acks, no further bursts, done pulses, level = 4.
5. Assert wb_rst_n low mid-burst after 2 acks → wb_cyc/wb_stb = 0 immediately, level = 0, busy = 0; a following start fetches correctly.
6. WB_BURST_FETCH_TIMEOUT_EN defined, responder never acks → at 1023 cycles of stb, stb drops, err = 1 and done pulses; the next start clears err.
